gc_issue_scheduler: RTL and testbench
=====================================

GC_ISSUE_SCHEDULER -- requirements
Module: gc_issue_scheduler

Interface
REQ-001 Parameter S, default 20: gate/wire index width.
REQ-002 Parameter L, default NR_AES: garbling pipeline latency in cycles, from gate issue to output-label write; L >= 1.
REQ-003 Port clk, input, 1: sole clock, rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: begin garbling one netlist.
REQ-006 Port num_gates, input, S: gate count, sampled when start is accepted.
REQ-007 Port dep0_v / dep1_v, input, 1 each: in0/in1 of the current gate is a gate output; excludes primary inputs and the R constant.
REQ-008 Port dep0_gid / dep1_gid, input, S each: producing gate id of in0/in1.
REQ-009 Port is_xor, input, 1: current gate is free-XOR class (XOR/XNOR/NOT), completing in the issue cycle.
REQ-010 Port gid, output, S: registered id of the gate presented to the datapath.
REQ-011 Port issue, output, 1: gate gid is issued this cycle.
REQ-012 Port const_en, output, 1: constant-label write cycle.
REQ-013 Port busy, output, 1: state is not IDLE.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port stall_cnt, output, 16: saturating count of hazard-stall cycles in the current run.

Function
REQ-016 States: IDLE, KEYS, CONST, ISSUE, DRAIN.
- IDLE -> KEYS on start; num_gates latched.
- KEYS -> CONST after 1 cycle.
- CONST -> ISSUE after 1 cycle; const_en=1 in CONST only.
REQ-017 In ISSUE: issue = ~hazard and gid < num_gates (combinational); gid increments by 1 on each issue cycle.
REQ-018 hazard = (dep0_v and dep0_gid matches any valid scoreboard entry) or (dep1_v and dep1_gid matches any valid scoreboard entry).
REQ-019 Scoreboard: L-entry shift register of {valid, gid}, shifted every cycle.
- Entry 0 loads {1, gid} when issue and ~is_xor.
- Entry 0 loads {0, x} otherwise.
- The oldest entry is discarded on each shift.
REQ-020 Scoreboard timing: a non-XOR producer issued in cycle t blocks its dependents in cycles t+1..t+L; a dependent issues no earlier than cycle t+L+1.
REQ-021 XOR-class producers never enter the scoreboard; a dependent may issue in the following cycle.
REQ-022 While hazard is asserted in ISSUE: issue=0, gid holds, stall_cnt increments and saturates at 16'hFFFF.
REQ-023 ISSUE -> DRAIN in the cycle the gate with gid = num_gates-1 issues.
REQ-024 DRAIN -> IDLE when the scoreboard holds no valid entry; done=1 during that transition cycle.
REQ-025 num_gates = 0: CONST -> DRAIN directly, with no issue; done follows one cycle later.
REQ-026 start is ignored while busy.
REQ-027 gid width arithmetic is modulo 2^S; num_gates is bounded by 2^S-1.

Reset
REQ-028 Reset is asynchronous and active-low (rst=0), effective immediately, including mid-run. Values on reset:
- state = IDLE
- gid = 0
- scoreboard fully invalid
- issue = 0, const_en = 0, busy = 0, done = 0
- stall_cnt = 0
REQ-029 On release, the block waits in IDLE for start; an aborted run is not resumed.
REQ-030 stall_cnt clears on start acceptance and holds its value after done.

Verification (L=10)
REQ-031 Chain of 3 AND gates, each depending on the previous; start -> issues at cycles c, c+11, c+22; stall_cnt=20; done at c+33.
REQ-032 Chain of 3 XOR gates, each depending on the previous -> issues on 3 consecutive cycles; stall_cnt=0; done 1 cycle after the last issue.
REQ-033 num_gates=0 -> const_en for 1 cycle, no issue, done 2 cycles after const_en, then busy=0.
REQ-034 rst asserted 4 cycles into a 100-gate run -> all outputs return to reset values in the same cycle; a new start re-runs from gid=0.
REQ-035 start pulsed while busy, plus 70000 forced stall cycles -> start has no effect; stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/gc_issue_scheduler.sv
// Issue scheduler for a garbled-circuit engine: walks gate ids in order and stalls any
// gate whose input label is still inside the L-cycle garbling pipeline.
module gc_issue_scheduler #(
  parameter int S = 20,
  parameter int L = 10  // NR_AES: AES-128 round count, one pipeline stage per round
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [S-1:0] num_gates,
  input  logic         dep0_v,
  input  logic [S-1:0] dep0_gid,
  input  logic         dep1_v,
  input  logic [S-1:0] dep1_gid,
  input  logic         is_xor,
  output logic [S-1:0] gid,
  output logic         issue,
  output logic         const_en,
  output logic         busy,
  output logic         done,
  output logic [15:0]  stall_cnt
);

  typedef enum logic [2:0] {IDLE, KEYS, CONST, ISSUE, DRAIN} state_t;

  state_t         state_reg, state_next;
  logic [S-1:0]   num_gates_reg;
  logic [S-1:0]   gid_reg;
  logic [15:0]    stall_reg;
  logic           hold_reg;
  logic [L-1:0]   sb_v_reg;
  logic [S-1:0]   sb_gid_reg [L];

  logic [L-1:0]   hit0, hit1;
  logic           hazard;
  logic           sb_any;
  logic           issue_ok;
  logic           last_issue;
  logic           accept;

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_hit
      assign hit0[gi] = sb_v_reg[gi] && (sb_gid_reg[gi] == dep0_gid);
      assign hit1[gi] = sb_v_reg[gi] && (sb_gid_reg[gi] == dep1_gid);
    end
  endgenerate

  assign hazard     = (dep0_v && |hit0) || (dep1_v && |hit1);
  assign sb_any     = |sb_v_reg;
  assign issue_ok   = (state_reg == ISSUE) && !hazard && (gid_reg < num_gates_reg);
  assign last_issue = issue_ok && (gid_reg == num_gates_reg - 1'b1);
  assign accept     = (state_reg == IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = KEYS;
      KEYS:    state_next = CONST;
      CONST:   state_next = (num_gates_reg == '0) ? DRAIN : ISSUE;
      ISSUE:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (!sb_any && !hold_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue    = issue_ok;
    const_en = (state_reg == CONST);
    busy     = (state_reg != IDLE);
    done     = (state_reg == DRAIN) && !sb_any && !hold_reg;
  end

  // An empty netlist lingers one cycle in DRAIN so done lands two cycles after const_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_gates_reg <= '0;
      gid_reg       <= '0;
      stall_reg     <= '0;
      hold_reg      <= 1'b0;
    end else begin
      hold_reg <= (state_reg == CONST) && (num_gates_reg == '0);
      if (accept) begin
        num_gates_reg <= num_gates;
        gid_reg       <= '0;
        stall_reg     <= '0;
      end else begin
        if (issue_ok) gid_reg <= gid_reg + 1'b1;
        if ((state_reg == ISSUE) && hazard && (stall_reg != 16'hFFFF))
          stall_reg <= stall_reg + 16'd1;
      end
    end
  end

  // Only gates that really occupy the AES pipeline are tracked; free-XOR gates finish at issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) begin
        sb_v_reg[i]   <= 1'b0;
        sb_gid_reg[i] <= '0;
      end
    end else begin
      sb_v_reg[0]   <= issue_ok && !is_xor;
      sb_gid_reg[0] <= gid_reg;
      for (int i = 1; i < L; i++) begin
        sb_v_reg[i]   <= sb_v_reg[i-1];
        sb_gid_reg[i] <= sb_gid_reg[i-1];
      end
    end
  end

  assign gid       = gid_reg;
  assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_gc_issue_scheduler.sv
// Bench for gc_issue_scheduler: a netlist model drives gate dependencies from gid,
// a scheduling model predicts issue cycles, and a queue scoreboard checks each issue.
module tb_gc_issue_scheduler;
  localparam int S = 20;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [S-1:0] num_gates = '0;
  logic         dep0_v, dep1_v, is_xor;
  logic [S-1:0] dep0_gid, dep1_gid;
  logic [S-1:0] gid;
  logic         issue, const_en, busy, done;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_mode = 0;

  typedef struct {int gid; int rel;} exp_t;
  exp_t q[$];

  typedef struct {int n; int mode; int exp_stall; int exp_done; bit pulse;} vec_t;
  vec_t vecs[6];

  gc_issue_scheduler #(.S(S), .L(L)) dut (
    .clk(clk), .rst(rst), .start(start), .num_gates(num_gates),
    .dep0_v(dep0_v), .dep0_gid(dep0_gid), .dep1_v(dep1_v), .dep1_gid(dep1_gid),
    .is_xor(is_xor), .gid(gid), .issue(issue), .const_en(const_en),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Modes: 0 independent AND, 1 AND chain on in0, 2 XOR chain, 3 AND chain on in1, 4 AND on gid-2
  function automatic void netlist(input int mode, input int k, output bit v0, output int g0,
                                  output bit v1, output int g1, output bit x);
    v0 = 0; g0 = 0; v1 = 0; g1 = 0; x = (mode == 2);
    case (mode)
      1, 2: begin v0 = (k > 0); g0 = k - 1; end
      3:    begin v0 = 1; g0 = k + 100; v1 = (k > 0); g1 = k - 1; end
      4:    begin v0 = (k > 1); g0 = k - 2; end
      default: ;
    endcase
  endfunction

  always_comb begin
    bit v0, v1, x;
    int g0, g1;
    netlist(cur_mode, int'(gid), v0, g0, v1, g1, x);
    dep0_v   = v0;
    dep0_gid = g0[S-1:0];
    dep1_v   = v1;
    dep1_gid = g1[S-1:0];
    is_xor   = x;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_case(input int n, input int mode, input int exp_stall, input int exp_done,
                          input bit pulse);
    int t[];
    bit xp[];
    int s, rel, done_rel, const_rel, const_cnt, stall_done, r;
    bit got_done, v0, v1, x;
    int g0, g1;
    exp_t e;
    t = new[n > 0 ? n : 1];
    xp = new[n > 0 ? n : 1];
    for (int k = 0; k < n; k++) begin
      netlist(mode, k, v0, g0, v1, g1, x);
      r = (k == 0) ? 3 : t[k-1] + 1;
      if (v0 && g0 < k && t[g0] + (xp[g0] ? 1 : L + 1) > r) r = t[g0] + (xp[g0] ? 1 : L + 1);
      if (v1 && g1 < k && t[g1] + (xp[g1] ? 1 : L + 1) > r) r = t[g1] + (xp[g1] ? 1 : L + 1);
      t[k] = r;
      xp[k] = x;
    end
    cur_mode = mode;
    @(negedge clk);
    num_gates = S'(n);
    start = 1'b1;
    s = cyc;
    for (int k = 0; k < n; k++) q.push_back('{k, t[k]});
    @(negedge clk);
    start = 1'b0;
    num_gates = S'(7);
    got_done = 0; done_rel = -1; const_rel = -1; const_cnt = 0; stall_done = -1;
    for (int i = 0; i < exp_done + 40 && !got_done; i++) begin
      rel = cyc - s;
      start = pulse && (rel == 50);
      if (start) num_gates = S'(5);
      if (issue) begin
        if (q.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          e = q.pop_front();
          check("issue_gid", int'(gid), e.gid);
          check("issue_cycle", rel, e.rel);
        end
      end
      if (const_en) begin const_cnt++; const_rel = rel; end
      if (done) begin got_done = 1; done_rel = rel; stall_done = int'(stall_cnt); end
      if (!got_done) @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    check("done_cycle", done_rel, exp_done);
    check("stall_cnt_at_done", stall_done, exp_stall);
    check("const_en_cycle", const_rel, 2);
    check("const_en_count", const_cnt, 1);
    check("issues_outstanding", q.size(), 0);
    q.delete();
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("stall_cnt_holds", int'(stall_cnt), exp_stall);
    $display("run n=%0d mode=%0d done_rel=%0d stall=%0d", n, mode, done_rel, stall_done);
  endtask

  initial begin
    vecs[0] = '{3, 1, 20, 36, 0};
    vecs[1] = '{3, 2, 0, 6, 0};
    vecs[2] = '{0, 0, 0, 4, 0};
    vecs[3] = '{5, 0, 0, 18, 0};
    vecs[4] = '{4, 3, 30, 47, 0};
    vecs[5] = '{6, 4, 18, 37, 0};

    #3;
    check("reset_busy", busy, 0);
    check("reset_issue", issue, 0);
    check("reset_gid", int'(gid), 0);
    check("reset_stall", int'(stall_cnt), 0);
    check("reset_const_en", const_en, 0);
    check("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++)
      run_case(vecs[i].n, vecs[i].mode, vecs[i].exp_stall, vecs[i].exp_done, vecs[i].pulse);

    // Long AND chain saturates the stall counter while start is pulsed mid-run
    run_case(7001, 1, 65535, 77014, 1);
    // Next run must clear the saturated counter on start
    run_case(3, 2, 0, 6, 0);

    // Asynchronous reset four cycles into a 100-gate run
    cur_mode = 0;
    @(negedge clk);
    num_gates = S'(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_gid_moving", int'(gid), 1);
    #2 rst = 1'b0;
    #1;
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_issue", issue, 0);
    check("midrun_reset_gid", int'(gid), 0);
    check("midrun_reset_stall", int'(stall_cnt), 0);
    check("midrun_reset_const_en", const_en, 0);
    check("midrun_reset_done", done, 0);
    q.delete();
    repeat (2) @(negedge clk);
    check("idle_after_reset_release", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("no_resume_after_reset", busy, 0);
    run_case(100, 0, 0, 113, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
